// File: rtl/ex_issue_stage.sv
// Execute-issue pipeline register: resolves operand forwarding (EX > MEM > WB
// > register file), detects load-use hazards, and holds one instruction for
// the ALU under a valid/ready handshake on both sides.
module ex_issue_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  id_sa,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_src_a_sa,
  input  logic        id_src_b_imm,
  input  logic        id_reg_we,
  input  logic        id_mem_rd,
  input  logic [5:0]  id_alu_op,
  input  logic        flush,
  input  logic [31:0] alu_result,
  input  logic        mem_fwd_we,
  input  logic [4:0]  mem_fwd_rd,
  input  logic [31:0] mem_fwd_data,
  input  logic        wb_fwd_we,
  input  logic [4:0]  wb_fwd_rd,
  input  logic [31:0] wb_fwd_data,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] ex_store_data,
  output logic [31:0] ex_pc,
  output logic [5:0]  alu_op,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_we,
  output logic        ex_mem_rd,
  output logic [15:0] stall_cnt
);

  logic        ex_fwd_en;
  logic        load_use;
  logic        transfer;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  // A held load cannot forward: its data only exists once it reaches MEM.
  assign ex_fwd_en = ex_valid && ex_reg_we && !ex_mem_rd && (ex_rd != '0);

  assign load_use = id_valid && ex_valid && ex_mem_rd && ex_reg_we && (ex_rd != '0) &&
                    ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  assign id_ready = (!ex_valid || ex_ready) && !load_use && !flush;
  assign transfer = id_valid && id_ready;

  // Forwarded rs value; register 0 always reads the register file.
  always_comb begin
    fwd_rs = id_rs_val;
    if (id_rs != '0) begin
      if (ex_fwd_en && (ex_rd == id_rs))                fwd_rs = alu_result;
      else if (mem_fwd_we && (mem_fwd_rd == id_rs))     fwd_rs = mem_fwd_data;
      else if (wb_fwd_we && (wb_fwd_rd == id_rs))       fwd_rs = wb_fwd_data;
    end
  end

  // Forwarded rt value; same priority as rs.
  always_comb begin
    fwd_rt = id_rt_val;
    if (id_rt != '0) begin
      if (ex_fwd_en && (ex_rd == id_rt))                fwd_rt = alu_result;
      else if (mem_fwd_we && (mem_fwd_rd == id_rt))     fwd_rt = mem_fwd_data;
      else if (wb_fwd_we && (wb_fwd_rd == id_rt))       fwd_rt = wb_fwd_data;
    end
  end

  // Pipeline register: reset > flush > capture > drain > hold.
  // Flush and drain clear only valid/control bits; data keeps its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      ex_store_data <= '0;
      ex_pc         <= '0;
      alu_op        <= '0;
      ex_rd         <= '0;
      ex_reg_we     <= 1'b0;
      ex_mem_rd     <= 1'b0;
    end else if (flush) begin
      ex_valid  <= 1'b0;
      ex_reg_we <= 1'b0;
      ex_mem_rd <= 1'b0;
    end else if (transfer) begin
      ex_valid      <= 1'b1;
      alu_a         <= id_src_a_sa ? {27'b0, id_sa} : fwd_rs;
      alu_b         <= id_src_b_imm ? id_imm : fwd_rt;
      ex_store_data <= fwd_rt;
      ex_pc         <= id_pc;
      alu_op        <= id_alu_op;
      ex_rd         <= id_rd;
      ex_reg_we     <= id_reg_we;
      ex_mem_rd     <= id_mem_rd;
    end else if (ex_ready) begin
      ex_valid  <= 1'b0;
      ex_reg_we <= 1'b0;
      ex_mem_rd <= 1'b0;
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (load_use && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_ex_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rs_val, id_rt_val, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd, id_sa;
  logic        id_use_rs, id_use_rt, id_src_a_sa, id_src_b_imm, id_reg_we, id_mem_rd;
  logic [5:0]  id_alu_op;
  logic        flush;
  logic [31:0] alu_result;
  logic        mem_fwd_we, wb_fwd_we;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_valid, ex_ready;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [5:0]  alu_op;
  logic [4:0]  ex_rd;
  logic        ex_reg_we, ex_mem_rd;
  logic [15:0] stall_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ex_issue_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_sa(id_sa),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_src_a_sa(id_src_a_sa),
    .id_src_b_imm(id_src_b_imm), .id_reg_we(id_reg_we), .id_mem_rd(id_mem_rd),
    .id_alu_op(id_alu_op), .flush(flush), .alu_result(alu_result),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .alu_a(alu_a), .alu_b(alu_b),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .alu_op(alu_op), .ex_rd(ex_rd),
    .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently held in EX.
  typedef struct {
    bit          valid;
    logic [31:0] a, b, sd, pc;
    logic [5:0]  op;
    logic [4:0]  rd;
    bit          we, mrd;
  } slot_t;

  slot_t       m;
  int unsigned m_stall;

  // Forward sources in priority order: index 0 = EX, 1 = MEM, 2 = WB.
  bit          src_en[3];
  logic [4:0]  src_rd[3];
  logic [31:0] src_val[3];

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
    logic [31:0] v = rf;
    if (r != 5'd0)
      for (int i = 2; i >= 0; i--)
        if (src_en[i] && src_rd[i] == r) v = src_val[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("ex_valid", {31'b0, ex_valid}, {31'b0, m.valid});
    chk("alu_a", alu_a, m.a);
    chk("alu_b", alu_b, m.b);
    chk("ex_store_data", ex_store_data, m.sd);
    chk("ex_pc", ex_pc, m.pc);
    chk("alu_op", {26'b0, alu_op}, {26'b0, m.op});
    chk("ex_rd", {27'b0, ex_rd}, {27'b0, m.rd});
    chk("ex_reg_we", {31'b0, ex_reg_we}, {31'b0, m.we});
    chk("ex_mem_rd", {31'b0, ex_mem_rd}, {31'b0, m.mrd});
    chk("stall_cnt", {16'b0, stall_cnt}, m_stall);
  endtask

  // One clock cycle with the inputs currently driven; called just after an edge.
  task automatic step();
    bit lu, rdy;
    #2;
    src_en[0] = m.valid && m.we && !m.mrd; src_rd[0] = m.rd;       src_val[0] = alu_result;
    src_en[1] = mem_fwd_we;                src_rd[1] = mem_fwd_rd; src_val[1] = mem_fwd_data;
    src_en[2] = wb_fwd_we;                 src_rd[2] = wb_fwd_rd;  src_val[2] = wb_fwd_data;
    lu = id_valid && m.valid && m.mrd && m.we && m.rd != 5'd0 &&
         ((id_use_rs && id_rs == m.rd) || (id_use_rt && id_rt == m.rd));
    rdy = (!m.valid || ex_ready) && !lu && !flush;
    if (!reset) chk("id_ready", {31'b0, id_ready}, {31'b0, rdy});
    @(posedge clk);
    if (reset) begin
      m = '{valid: 0, a: 0, b: 0, sd: 0, pc: 0, op: 0, rd: 0, we: 0, mrd: 0};
      m_stall = 0;
    end else begin
      if (lu && m_stall < 32'hFFFF) m_stall++;
      if (flush) begin
        m.valid = 0; m.we = 0; m.mrd = 0;
      end else if (id_valid && rdy) begin
        m.valid = 1;
        m.a   = id_src_a_sa ? {27'b0, id_sa} : fwd(id_rs, id_rs_val);
        m.b   = id_src_b_imm ? id_imm : fwd(id_rt, id_rt_val);
        m.sd  = fwd(id_rt, id_rt_val);
        m.pc  = id_pc; m.op = id_alu_op; m.rd = id_rd;
        m.we  = id_reg_we; m.mrd = id_mem_rd;
      end else if (ex_ready) begin
        m.valid = 0; m.we = 0; m.mrd = 0;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic clr();
    reset = 0; id_valid = 0; id_pc = 0; id_rs_val = 0; id_rt_val = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_sa = 0; id_use_rs = 0; id_use_rt = 0;
    id_src_a_sa = 0; id_src_b_imm = 0; id_reg_we = 0; id_mem_rd = 0; id_alu_op = 0;
    flush = 0; alu_result = 0; mem_fwd_we = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_we = 0; wb_fwd_rd = 0; wb_fwd_data = 0; ex_ready = 1;
  endtask

  task automatic rand_inputs();
    reset = ($urandom_range(0, 99) < 3);
    id_valid = ($urandom_range(0, 99) < 75);
    id_pc = $urandom; id_rs_val = $urandom; id_rt_val = $urandom; id_imm = $urandom;
    id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
    id_rd = 5'($urandom_range(0, 7)); id_sa = 5'($urandom);
    id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
    id_src_a_sa = ($urandom_range(0, 9) == 0); id_src_b_imm = 1'($urandom);
    id_reg_we = ($urandom_range(0, 9) < 8); id_mem_rd = ($urandom_range(0, 9) < 3);
    id_alu_op = 6'($urandom);
    flush = ($urandom_range(0, 99) < 8);
    alu_result = $urandom;
    mem_fwd_we = 1'($urandom); mem_fwd_rd = 5'($urandom_range(0, 7)); mem_fwd_data = $urandom;
    wb_fwd_we = 1'($urandom); wb_fwd_rd = 5'($urandom_range(0, 7)); wb_fwd_data = $urandom;
    ex_ready = ($urandom_range(0, 99) < 70);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_stall = 0;
    clr();
    // Start in an arbitrary state, then reset.
    id_valid = 1; id_rd = 9; id_reg_we = 1; id_pc = 32'h1234;
    @(posedge clk); #1;
    m = '{valid: 1, a: 0, b: 0, sd: 0, pc: 0, op: 0, rd: 0, we: 0, mrd: 0};
    reset = 1;
    step();
    chk("reset_valid", {31'b0, ex_valid}, 32'd0);
    chk("reset_pc", ex_pc, 32'd0);

    // Dependent back-to-back ALU ops: EX forward beats register file.
    clr(); id_valid = 1; id_rd = 3; id_reg_we = 1; id_pc = 32'h100;
    step();
    clr(); id_valid = 1; id_rs = 3; id_use_rs = 1; id_rs_val = 32'h99; alu_result = 32'h10;
    step();
    chk("dep_add_alu_a", alu_a, 32'h10);

    // MEM beats WB; rd=0 sources never forward.
    clr(); id_valid = 1; id_rt = 5; id_use_rt = 1; id_rt_val = 32'h55;
    mem_fwd_we = 1; mem_fwd_rd = 5; mem_fwd_data = 32'hA;
    wb_fwd_we = 1; wb_fwd_rd = 5; wb_fwd_data = 32'hB;
    step();
    chk("prio_alu_b", alu_b, 32'hA);
    mem_fwd_rd = 0; wb_fwd_rd = 0;
    step();
    chk("rd0_src_alu_b", alu_b, 32'h55);
    id_rt = 0; id_rt_val = 32'h66;
    step();
    chk("r0_operand_alu_b", alu_b, 32'h66);

    // Load-use: one bubble, then capture with the MEM-forwarded value.
    clr(); id_valid = 1; id_rd = 7; id_reg_we = 1; id_mem_rd = 1;
    step();
    clr(); id_valid = 1; id_rs = 7; id_use_rs = 1; id_rs_val = 32'h55;
    #1;
    chk("lu_id_ready", {31'b0, id_ready}, 32'd0);
    step();
    chk("lu_bubble", {31'b0, ex_valid}, 32'd0);
    chk("lu_stall_cnt", {16'b0, stall_cnt}, 32'd1);
    mem_fwd_we = 1; mem_fwd_rd = 7; mem_fwd_data = 32'h77;
    step();
    chk("lu_fwd_alu_a", alu_a, 32'h77);

    // Backpressure for three cycles, then release.
    clr(); id_valid = 1; id_pc = 32'h200; id_rd = 4; id_reg_we = 1;
    step();
    ex_ready = 0; id_pc = 32'h204;
    repeat (3) step();
    chk("bp_hold_pc", ex_pc, 32'h200);
    chk("bp_id_ready", {31'b0, id_ready}, 32'd0);
    ex_ready = 1;
    step();
    chk("bp_release_pc", ex_pc, 32'h204);

    // Flush with a pending decode transfer.
    id_pc = 32'h300; flush = 1;
    step();
    chk("flush_valid", {31'b0, ex_valid}, 32'd0);
    chk("flush_reg_we", {31'b0, ex_reg_we}, 32'd0);
    chk("flush_no_capture", ex_pc, 32'h204);

    // Shift-amount operand.
    clr(); id_valid = 1; id_src_a_sa = 1; id_sa = 5'd31; id_alu_op = 6'b000110;
    id_rs_val = 32'hDEAD;
    step();
    chk("shift_alu_a", alu_a, 32'h1F);
    chk("shift_alu_op", {26'b0, alu_op}, 32'd6);

    // Random traffic with occasional resets and flushes.
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      step();
    end

    // Reset mid-stream clears everything.
    rand_inputs(); reset = 1;
    step();
    chk("final_reset_alu_a", alu_a, 32'd0);
    chk("final_reset_stall", {16'b0, stall_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_issue_stage.md
EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 id_valid / id_ready  in / out  1 / 1  decode-side handshake; transfer on id_valid && id_ready.
REQ-004 id_pc, id_rs_val, id_rt_val, id_imm  in  32 each  decode PC, register-file read data, extended immediate.
REQ-005 id_rs, id_rt, id_rd, id_sa  in  5 each  source/destination register numbers, shift amount.
REQ-006 id_use_rs, id_use_rt, id_src_a_sa, id_src_b_imm, id_reg_we, id_mem_rd  in  1 each  operand-use flags, operand selects, writeback enable, load flag.
REQ-007 id_alu_op  in  6  ALU operation code; passed through unchanged.
REQ-008 flush  in  1  kill the held instruction.
REQ-009 alu_result  in  32  combinational ALU result for the held instruction.
REQ-010 mem_fwd_we, mem_fwd_rd, mem_fwd_data  in  1/5/32  MEM-stage forward source.
REQ-011 wb_fwd_we, wb_fwd_rd, wb_fwd_data  in  1/5/32  WB-stage forward source.
REQ-012 ex_valid / ex_ready  out / in  1 / 1  downstream handshake; held instruction leaves on ex_valid && ex_ready.
REQ-013 alu_a, alu_b, ex_store_data, ex_pc  out  32 each  registered ALU operands, store data, PC.
REQ-014 alu_op  out  6;  ex_rd  out  5;  ex_reg_we, ex_mem_rd  out  1 each;  stall_cnt  out  16.

Function
REQ-015 Forwarded rs/rt value SHALL use priority EX > MEM > WB > register file; a source matches when its we=1, its rd equals the operand number, and rd != 0.
REQ-016 The EX source SHALL be alu_result, qualified by ex_valid && ex_reg_we && !ex_mem_rd, with ex_rd as its rd.
REQ-017 Register number 0 SHALL never be forwarded; the operand SHALL take id_*_val.
REQ-018 Next alu_a SHALL be {27'b0, id_sa} when id_src_a_sa=1, else forwarded rs.
REQ-019 Next alu_b SHALL be id_imm when id_src_b_imm=1, else forwarded rt.
REQ-020 Next ex_store_data SHALL always be forwarded rt.
REQ-021 load_use SHALL be: id_valid && ex_valid && ex_mem_rd && ex_reg_we && ex_rd != 0 && ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd)).
REQ-022 id_ready SHALL be (!ex_valid || ex_ready) && !load_use && !flush.
REQ-023 Capture: on transfer, every ex_* and alu_* register SHALL load at the next edge, with ex_valid=1 (latency 1 cycle).
REQ-024 Drain: with no transfer and ex_ready=1, ex_valid SHALL go to 0 and ex_reg_we and ex_mem_rd SHALL clear (bubble).
REQ-025 Hold: with ex_valid=1 and ex_ready=0, all outputs SHALL hold unchanged.
REQ-026 During a bubble, data outputs SHALL keep their last values; only the valid and control bits clear.
REQ-027 Flush SHALL clear ex_valid, ex_reg_we and ex_mem_rd at the next edge, override capture and hold, and accept no decode transfer that cycle.
REQ-028 Update priority SHALL be: reset > flush > capture > drain > hold.
REQ-029 stall_cnt SHALL increment each cycle load_use=1 and saturate at 16'hFFFF.

Reset
REQ-030 While reset=1 at an edge, all outputs and registers SHALL become 0, including ex_valid and stall_cnt.
REQ-031 Reset asserted mid-hold or mid-load-use SHALL discard the held instruction, with no residual forwarding.
REQ-032 In the cycle reset is asserted, id_ready SHALL be don't-care; the first transfer is allowed in the cycle after reset deasserts.

Verification
REQ-033 Back-to-back dependent add: held rd=3, alu_result=0x10, next rs=3, id_rs_val=0x99 -> alu_a=0x10 next cycle.
REQ-034 Forward priority: MEM rd=5 data 0xA and WB rd=5 data 0xB, rt=5, id_src_b_imm=0 -> alu_b=0xA; with rd=0 on both sources -> alu_b=id_rt_val.
REQ-035 Load-use: held load rd=7, next id_rs=7, ex_ready=1 -> id_ready=0 for 1 cycle, bubble (ex_valid=0) emitted, stall_cnt=1; instruction then captured using the MEM-forwarded value.
REQ-036 Backpressure: ex_ready=0 for 3 cycles with id_valid=1 -> outputs stable, id_ready=0; ex_ready=1 -> new instruction captured next edge.
REQ-037 Flush with id_valid=1 and ex_valid=1 -> ex_valid=0, ex_reg_we=0 next edge; no capture.
REQ-038 Shift: id_src_a_sa=1, id_sa=5'd31, id_alu_op=6'b000110 -> alu_a=0x0000001F, alu_op=6'b000110; reset mid-stream -> all outputs 0.
